// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined unsigned adder/subtractor, CHUNK bits of ripple per stage
// Each stage registers its resolved low result bits plus only the operand bits still pending.
module addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MODE,
  input  logic             SAT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] D,
  output logic             COUT
);
  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic en;

  assign en       = !OUT_VALID || OUT_READY;
  assign IN_READY = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * CHUNK;
    localparam int IW   = WIDTH - LO;
    localparam int NB   = (IW < CHUNK) ? IW : CHUNK;
    localparam int HI   = LO + NB;
    localparam bit LAST = (k == STAGES - 1);

    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic          mode_in;
    logic          sat_in;
    logic          c_in;
    logic          v_in;
    logic [NB:0]   cy;
    logic [NB-1:0] res;
    logic [HI-1:0] raw;
    logic [HI-1:0] d_d;
    logic [HI-1:0] d_q;
    logic          c_d;
    logic          c_q;
    logic          v_d;
    logic          v_q;

    if (k == 0) begin : g_src
      assign a_in    = A;
      assign b_in    = B;
      assign mode_in = MODE;
      assign sat_in  = SAT;
      assign c_in    = 1'b0;
      assign v_in    = IN_VALID;
      assign raw     = res;
    end else begin : g_src
      assign a_in    = g_stage[k-1].g_ops.a_q;
      assign b_in    = g_stage[k-1].g_ops.b_q;
      assign mode_in = g_stage[k-1].g_ops.mode_q;
      assign sat_in  = g_stage[k-1].g_ops.sat_q;
      assign c_in    = g_stage[k-1].c_q;
      assign v_in    = g_stage[k-1].v_q;
      assign raw     = {res, g_stage[k-1].d_q};
    end

    // Bit-serial ripple; cy carries the carry (add) or the borrow (sub).
    assign cy[0] = c_in;
    for (genvar j = 0; j < NB; j++) begin : g_bit
      logic ai;
      logic bi;
      logic p;
      assign ai        = a_in[j];
      assign bi        = b_in[j];
      assign p         = ai ^ bi;
      assign res[j]    = p ^ cy[j];
      assign cy[j+1]   = mode_in ? ((~ai & bi) | (~p & cy[j]))
                                 : ((ai & bi) | (p & cy[j]));
    end

    always_comb begin
      v_d = v_q;
      d_d = d_q;
      c_d = c_q;
      if (en) begin
        v_d = v_in;
        d_d = raw;
        c_d = cy[NB];
        if (LAST && sat_in && cy[NB]) begin
          d_d = mode_in ? '0 : '1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        c_q <= 1'b0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
        c_q <= c_d;
      end
    end

    if (!LAST) begin : g_ops
      logic [IW-NB-1:0] a_d;
      logic [IW-NB-1:0] a_q;
      logic [IW-NB-1:0] b_d;
      logic [IW-NB-1:0] b_q;
      logic             mode_d;
      logic             mode_q;
      logic             sat_d;
      logic             sat_q;

      always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        sat_d  = sat_q;
        if (en) begin
          a_d    = a_in[IW-1:NB];
          b_d    = b_in[IW-1:NB];
          mode_d = mode_in;
          sat_d  = sat_in;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q    <= '0;
          b_q    <= '0;
          mode_q <= 1'b0;
          sat_q  <= 1'b0;
        end else begin
          a_q    <= a_d;
          b_q    <= b_d;
          mode_q <= mode_d;
          sat_q  <= sat_d;
        end
      end
    end
  end

  assign OUT_VALID = g_stage[STAGES-1].v_q;
  assign D         = g_stage[STAGES-1].d_q;
  assign COUT      = g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - scoreboard bench for addsub_pipe (8/4 main instance, 13/5 latency instance)
module tb_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a_i = '0;
  logic [7:0]  b_i = '0;
  logic        mode_i = 1'b0;
  logic        sat_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  d_o;
  logic        cout_o;

  logic        v13 = 1'b0;
  logic        ir13;
  logic [12:0] a13 = '0;
  logic [12:0] b13 = '0;
  logic        m13 = 1'b0;
  logic        s13 = 1'b0;
  logic        ov13;
  logic        r13 = 1'b1;
  logic [12:0] d13;
  logic        c13;

  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  logic [8:0]  exp_q[$];
  logic        s_ov, s_acc, stalled = 1'b0;
  logic [7:0]  hold_d;
  logic        hold_c;

  addsub_pipe #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
    .A(a_i), .B(b_i), .MODE(mode_i), .SAT(sat_i),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .D(d_o), .COUT(cout_o)
  );

  addsub_pipe #(.WIDTH(13), .CHUNK(5)) dut13 (
    .clk(clk), .rst_n(rst_n), .IN_VALID(v13), .IN_READY(ir13),
    .A(a13), .B(b13), .MODE(m13), .SAT(s13),
    .OUT_VALID(ov13), .OUT_READY(r13), .D(d13), .COUT(c13)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic mode, input logic sat);
    logic [8:0] r;
    if (mode) begin
      r[7:0] = a - b;
      r[8]   = (a < b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    if (sat && r[8]) r[7:0] = mode ? 8'h00 : 8'hFF;
    return r;
  endfunction

  // One clock: sample at the falling edge, then return just after the next rising edge.
  task automatic cycle();
    logic [8:0] e;
    @(negedge clk);
    ncyc++;
    check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (stalled) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_d", 32'(d_o), 32'(hold_d));
      check("hold_cout", 32'(cout_o), 32'(hold_c));
    end
    stalled = out_valid && !out_ready;
    hold_d  = d_o;
    hold_c  = cout_o;
    s_ov    = out_valid;
    s_acc   = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_d", 32'(d_o), 32'(e[7:0]));
        check("sb_cout", 32'(cout_o), 32'(e[8]));
      end
    end
    if (s_acc) exp_q.push_back(model(a_i, b_i, mode_i, sat_i));
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic mode, input logic sat, input logic [7:0] exp_d,
                          input logic exp_c);
    int t0;
    a_i = a; b_i = b; mode_i = mode; sat_i = sat;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    check({tag, "_acc"}, 32'(s_acc), 32'd1);
    t0 = ncyc;
    in_valid = 1'b0;
    do cycle(); while (!s_ov && (ncyc - t0) < 10);
    check({tag, "_lat"}, 32'(ncyc - t0), 32'd2);
    check({tag, "_d"}, 32'(hold_d), 32'(exp_d));
    check({tag, "_cout"}, 32'(hold_c), 32'(exp_c));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard, lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d_o), 32'd0);
    check("rst_cout", 32'(cout_o), 32'd0);
    check("rst_valid13", 32'(ov13), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cycle();

    directed("t1", 8'h5A, 8'h23, 1'b1, 1'b0, 8'h37, 1'b0);
    directed("t2raw", 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b1);
    directed("t2sat", 8'h10, 8'h20, 1'b1, 1'b1, 8'h00, 1'b1);
    directed("t3raw", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    directed("t3sat", 8'hFF, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
    directed("t_eq", 8'h80, 8'h80, 1'b1, 1'b1, 8'h00, 1'b0);

    // Random back-to-back stream with random backpressure; each op held until accepted.
    n = 0;
    guard = 0;
    a_i = 8'($urandom); b_i = 8'($urandom); mode_i = 1'($urandom); sat_i = 1'($urandom);
    while (n < 16 && guard < 300) begin
      in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      guard++;
      if (s_acc) begin
        n++;
        a_i = 8'($urandom); b_i = 8'($urandom); mode_i = 1'($urandom); sat_i = 1'($urandom);
      end
    end
    check("stream_sent", 32'(n), 32'd16);
    in_valid = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      guard++;
    end
    check("stream_drain", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
    repeat (2) cycle();

    // Reset with two ops in flight.
    in_valid = 1'b1;
    a_i = 8'h10; b_i = 8'h20; mode_i = 1'b1; sat_i = 1'b0;
    cycle();
    a_i = 8'h21; b_i = 8'h13; mode_i = 1'b0;
    cycle();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_d", 32'(d_o), 32'd0);
    check("async_rst_cout", 32'(cout_o), 32'd0);
    exp_q.delete();
    stalled = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle();
    directed("post_rst", 8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0);

    // 13-bit, 5-bit chunk instance: borrow ripples through all three stages.
    a13 = 13'h1000; b13 = 13'h0001; m13 = 1'b1; s13 = 1'b0; r13 = 1'b1; v13 = 1'b1;
    @(negedge clk);
    check("w13_acc", 32'(ir13), 32'd1);
    @(posedge clk);
    #1;
    v13 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ov13) begin
        lat = k;
        check("w13_d", 32'(d13), 32'h0FFF);
        check("w13_cout", 32'(c13), 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    check("w13_lat", 32'(lat), 32'd3);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
